accum_sequencer: RTL and testbench

ACCUM_SEQUENCER -- requirements
Module: accum_sequencer

---
 rtl/accum_sequencer.sv | 149 ++++++++++++++
 tb/tb_accum_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_sequencer.sv
// Sequences a counted burst of operands into Load/Add commands for a downstream accumulator,
// keeping a shadow running Sum and sticky carry flag; all outputs come straight from flops.
module accum_sequencer #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          CLK,
  input  logic          Clrn,
  input  logic          Start,
  input  logic [CW-1:0] Count,
  input  logic [W-1:0]  Din,
  input  logic          DinValid,
  output logic          DinReady,
  output logic [W-1:0]  A,
  output logic          Add,
  output logic          Load,
  output logic          AccClrn,
  output logic [W-1:0]  Sum,
  output logic          Ovf,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FIRST,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          add_q, add_d;
  logic          load_q, load_d;
  logic          acc_clrn_q, acc_clrn_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          din_rdy_q, din_rdy_d;

  logic          xfer;
  logic [CW-1:0] rem_dec;
  logic [W:0]    sum_ext;

  assign xfer    = DinValid && din_rdy_q;
  assign rem_dec = rem_q - {{(CW-1){1'b0}}, 1'b1};
  assign sum_ext = {1'b0, sum_q} + {1'b0, Din};

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sum_d      = sum_q;
    ovf_d      = ovf_q;
    add_d      = 1'b0;
    load_d     = 1'b0;
    acc_clrn_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (Start) begin
          rem_d      = Count;
          sum_d      = '0;
          ovf_d      = 1'b0;
          acc_clrn_d = 1'b0;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        state_d = (rem_q != '0) ? FIRST : DONE;
      end
      FIRST: begin
        if (xfer) begin
          load_d  = 1'b1;
          sum_d   = Din;
          rem_d   = rem_dec;
          state_d = (rem_dec != '0) ? ACCUM : DRAIN;
        end
      end
      ACCUM: begin
        if (xfer) begin
          add_d   = 1'b1;
          sum_d   = sum_ext[W-1:0];
          ovf_d   = ovf_q | sum_ext[W];
          rem_d   = rem_dec;
          state_d = (rem_dec != '0) ? ACCUM : DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Without a command, A mirrors Sum so the downstream default load of A keeps B intact.
    if (load_d || add_d) begin
      a_d = Din;
    end else if (!acc_clrn_d) begin
      a_d = '0;
    end else begin
      a_d = sum_d;
    end

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    din_rdy_d = (state_d == FIRST) || (state_d == ACCUM);
  end

  always_ff @(posedge CLK) begin
    if (!Clrn) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      a_q        <= '0;
      sum_q      <= '0;
      add_q      <= 1'b0;
      load_q     <= 1'b0;
      acc_clrn_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      din_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      a_q        <= a_d;
      sum_q      <= sum_d;
      add_q      <= add_d;
      load_q     <= load_d;
      acc_clrn_q <= acc_clrn_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      din_rdy_q  <= din_rdy_d;
    end
  end

  assign DinReady = din_rdy_q;
  assign A        = a_q;
  assign Add      = add_q;
  assign Load     = load_q;
  assign AccClrn  = acc_clrn_q;
  assign Sum      = sum_q;
  assign Ovf      = ovf_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench for accum_sequencer: expected sequence results are queued at stimulus time
// and checked by a negedge monitor that also models the downstream B register.
module tb_accum_sequencer;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          Clrn, Start, DinValid;
  logic [CW-1:0] Count;
  logic [W-1:0]  Din;
  logic          DinReady, Add, Load, AccClrn, Ovf, Busy, Done;
  logic [W-1:0]  A, Sum;

  always #5 CLK = ~CLK;

  accum_sequencer #(.W(W), .CW(CW)) dut (
    .CLK(CLK), .Clrn(Clrn), .Start(Start), .Count(Count), .Din(Din),
    .DinValid(DinValid), .DinReady(DinReady), .A(A), .Add(Add), .Load(Load),
    .AccClrn(AccClrn), .Sum(Sum), .Ovf(Ovf), .Busy(Busy), .Done(Done)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         ovf;
    int           nload;
    int           nadd;
    int           span;   // Done cycle minus first command cycle, -1 = unchecked
    int           s2d;    // Done cycle minus Start cycle, -1 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic void push(logic [W-1:0] s, logic o, int nl, int na, int sp, int sd);
    exp_t e;
    e.sum = s; e.ovf = o; e.nload = nl; e.nadd = na; e.span = sp; e.s2d = sd;
    exp_q.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  logic         clrn_s;
  logic         clrn_s_prev = 1'b1;
  logic         chk_clear = 1'b0, done_prev = 1'b0, b_valid = 1'b0;
  logic [W-1:0] b, sum_prev;
  int cyc = 0, nload = 0, nadd = 0, ncmd = 0;
  int last_xfer = 0, start_cyc = 0, first_cmd = -1;
  exp_t e;

  always @(posedge CLK) clrn_s <= Clrn;

  always @(negedge CLK) begin
    cyc++;
    if (clrn_s !== 1'b1) begin
      chk("reset_outputs", {A, Sum, Add, Load, AccClrn, DinReady, Busy, Done, Ovf}, 32'h0);
      nload = 0; nadd = 0; first_cmd = -1; done_prev = 1'b0;
    end else begin
      if (clrn_s_prev === 1'b0 && !chk_clear)
        chk("first_idle_after_reset", {AccClrn, A, Sum}, {1'b1, 16'h0});
      ncmd = int'(Add) + int'(Load) + int'(!AccClrn);
      chk("one_command", ncmd, 1'b1 ? (ncmd <= 1 ? ncmd : 1) : 0);
      if (!Add && !Load && AccClrn) chk("hold_a_eq_sum", A, Sum);
      if (b_valid) chk("b_tracks_sum", b, sum_prev);
      if (chk_clear)
        chk("clear_cycle", {AccClrn, A, Sum, Ovf, Busy, DinReady}, {1'b0, 8'h0, 8'h0, 1'b0, 1'b1, 1'b0});
      if (done_prev) chk("busy_after_done", Busy, 1'b0);
      if (Load || Add) begin
        if (Load) nload++;
        if (Add) nadd++;
        if (first_cmd < 0) first_cmd = cyc;
      end
      if (Done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done_queue", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("done_sum", Sum, e.sum);
          chk("done_ovf", Ovf, e.ovf);
          chk("done_b_model", b, e.sum);
          chk("done_nload", nload, e.nload);
          chk("done_nadd", nadd, e.nadd);
          if (e.nload > 0) chk("done_latency", cyc - last_xfer, 2);
          if (e.span >= 0) chk("cmd_span", cyc - first_cmd, e.span);
          if (e.s2d >= 0) chk("start_to_done", cyc - start_cyc, e.s2d);
        end
        nload = 0; nadd = 0; first_cmd = -1;
      end
      done_prev = Done;
    end
    // Inputs are stable here, so they are exactly what the next edge samples.
    chk_clear = 1'b0;
    if (Clrn && Start && !Busy) begin
      chk_clear = 1'b1;
      start_cyc = cyc;
    end
    if (Clrn && DinValid && DinReady) last_xfer = cyc;
    if (AccClrn === 1'b0) begin
      b = '0;
      b_valid = 1'b1;
    end else if (Load) b = A;
    else if (Add) b = b + A;
    else b = A;
    sum_prev = Sum;
    clrn_s_prev = clrn_s;
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic start(input logic [CW-1:0] cnt);
    Start = 1'b1;
    Count = cnt;
    @(posedge CLK);
    #1;
    Start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    Din = d;
    DinValid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      rdy = DinReady;
      @(posedge CLK);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_accept_timeout", rdy, 1'b1);
    DinValid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (Busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_idle_timeout", Busy, 1'b0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Clrn = 1'b0; Start = 1'b0; Count = '0; Din = '0; DinValid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    Clrn = 1'b1;
    idle(2);

    // three back-to-back operands
    push(8'h60, 1'b0, 1, 2, 3, -1);
    start(4'd3);
    send(8'h10); send(8'h20); send(8'h30);
    wait_idle();
    idle(1);

    // carry out sets Ovf
    push(8'h10, 1'b1, 1, 1, 2, -1);
    start(4'd2);
    send(8'hF0); send(8'h20);
    wait_idle();

    // gaps between operands; the clear cycle also shows Ovf dropped by the new Start
    push(8'h0C, 1'b0, 1, 1, -1, -1);
    start(4'd2);
    send(8'h05);
    idle(3);
    send(8'h07);
    wait_idle();

    // empty sequence
    push(8'h00, 1'b0, 0, 0, -1, 2);
    start(4'd0);
    wait_idle();

    // Start pulsed while accumulating is ignored
    push(8'h0A, 1'b0, 1, 3, 4, -1);
    start(4'd4);
    send(8'h01); send(8'h02);
    Start = 1'b1;
    Count = 4'd7;
    send(8'h03);
    Start = 1'b0;
    send(8'h04);
    wait_idle();
    idle(2);

    // reset in the middle of a sequence: no Done expected
    start(4'd4);
    send(8'h11); send(8'h22);
    Clrn = 1'b0;
    idle(2);
    Clrn = 1'b1;
    idle(3);

    // single operand goes FIRST -> DRAIN
    push(8'hAB, 1'b0, 1, 0, 1, -1);
    start(4'd1);
    send(8'hAB);
    wait_idle();

    // exact wrap to zero with carry
    push(8'h00, 1'b1, 1, 1, 2, -1);
    start(4'd2);
    send(8'h80); send(8'h80);
    wait_idle();

    // maximum count
    push(8'hFF, 1'b0, 1, 14, 15, -1);
    start(4'd15);
    for (int i = 0; i < 15; i++) send(8'h11);
    wait_idle();

    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
